// File: rtl/lane_stream_mux_if.sv
// Lane bus and valid/ready handshake between the lane sequencer and its neighbours.
// master = the side issuing runs and consuming beats; slave = the sequencer.
interface lane_stream_mux_if #(
    parameter int LANE_W  = 8,
    parameter int N_LANES = 24
);
    localparam int IDX_W = $clog2(N_LANES);
    localparam int CNT_W = $clog2(N_LANES + 1);

    logic [N_LANES*LANE_W-1:0] lanes_in;
    logic                      start;
    logic [IDX_W-1:0]          first_idx;
    logic [CNT_W-1:0]          count;
    logic                      flush;
    logic                      out_ready;
    logic                      out_valid;
    logic [LANE_W-1:0]         out_data;
    logic [IDX_W-1:0]          out_idx;
    logic                      busy;
    logic                      done;

    modport master (
        output lanes_in, start, first_idx, count, flush, out_ready,
        input  out_valid, out_data, out_idx, busy, done
    );

    modport slave (
        input  lanes_in, start, first_idx, count, flush, out_ready,
        output out_valid, out_data, out_idx, busy, done
    );
endinterface

// File: rtl/lane_stream_mux.sv
// Registered lane sequencer: snapshots N_LANES lanes and streams a wrapping run of them,
// one lane per beat, over valid/ready.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | no run; start with count!=0 captures the snapshot
//   S_STREAM | presenting snapshot[idx]; remaining counts beats still owed
module lane_stream_mux #(
    parameter int LANE_W  = 8,
    parameter int N_LANES = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    lane_stream_mux_if.slave bus
);
    localparam int IDX_W = $clog2(N_LANES);
    localparam int CNT_W = $clog2(N_LANES + 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t             state_q, state_d;
    logic [LANE_W-1:0]  snap_q [N_LANES];
    logic [LANE_W-1:0]  snap_d [N_LANES];
    logic [LANE_W-1:0]  lanes_arr [N_LANES];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic [LANE_W-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [CNT_W-1:0]   start_rem;
    logic               xfer;

    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            lanes_arr[i] = bus.lanes_in[i*LANE_W +: LANE_W];
        end
    end

    // Out-of-range start index falls back to lane 0; over-long runs clamp to one full lap.
    always_comb begin
        start_idx = (32'(bus.first_idx) >= N_LANES) ? '0 : bus.first_idx;
        start_rem = (32'(bus.count) > N_LANES) ? CNT_W'(N_LANES) : bus.count;
        next_idx  = (32'(idx_q) == N_LANES - 1) ? '0 : idx_q + IDX_W'(1);
        xfer      = out_valid_q & bus.out_ready;
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (bus.flush) begin
            state_d     = S_IDLE;
            rem_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            snap_d      = lanes_arr;
                            idx_d       = start_idx;
                            rem_d       = start_rem;
                            out_valid_d = 1'b1;
                            out_data_d  = lanes_arr[start_idx];
                            out_idx_d   = start_idx;
                            busy_d      = 1'b1;
                            state_d     = S_STREAM;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q > CNT_W'(1)) begin
                            idx_d      = next_idx;
                            out_data_d = snap_q[next_idx];
                            out_idx_d  = next_idx;
                        end else begin
                            state_d     = S_IDLE;
                            out_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < N_LANES; i++) begin
                snap_q[i] <= '0;
            end
            idx_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
